reg_writeback_ctrl: RTL and testbench
=====================================

REG_WRITEBACK_CTRL -- requirements
Module: reg_writeback_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have port: rst  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: pipe_valid in 1, pipe_reg in 5, pipe_data in 32; single-cycle WB-stage result, never stalled.
REQ-004 SHALL have ports: mdu_valid in 1, mdu_reg in 5, mdu_data in 32, mdu_ready out 1; long-latency unit result, valid/ready handshake.
REQ-005 SHALL have ports: RegWrite out 1, WriteReg out 5, WriteData out 32; register-file write port, all registered.
REQ-006 SHALL have ports: rd_reg1 in 5, rd_reg2 in 5, pend1 out 1, pend2 out 1; combinational pending-write query from decode.
REQ-007 SHALL have ports: byp1_valid out 1, byp1_data out 32, byp2_valid out 1, byp2_data out 32; combinational bypass from queue.

Function
REQ-008 SHALL hold a 4-entry FIFO of MDU results (reg, data, live bit) with 3-bit occupancy counter 0..4; pointers wrap mod 4.
REQ-009 SHALL assert mdu_ready = (count < 4); MDU transfer occurs when mdu_valid && mdu_ready at rising edge.
REQ-010 SHALL discard any write with target reg 0 (pipe or MDU): no enqueue, no RegWrite; MDU handshake still completes.
REQ-011 SHALL give pipe priority: pipe_valid && pipe_reg!=0 at edge N drives RegWrite=1, WriteReg=pipe_reg, WriteData=pipe_data in cycle N+1.
REQ-012 SHALL, when no pipe write at edge N and FIFO head live, drive head onto write port in cycle N+1 and pop it; dead head pops with RegWrite=0.
REQ-013 SHALL, when neither source writes, drive RegWrite=0 with WriteReg/WriteData holding last values.
REQ-014 SHALL accept an enqueue and a pop at the same edge; count unchanged; enqueue at count 4 never occurs.
REQ-015 SHALL treat pipe writes as younger than queued entries: a pipe write to register R clears the live bit of every queued entry targeting R.
REQ-016 SHALL clear live bits of queued entries targeting R when a newer MDU entry targeting R is enqueued (only youngest stays live).
REQ-017 SHALL assert pendX=1 when any live queued entry targets rd_regX and rd_regX!=0; a same-cycle MDU enqueue counts as queued.
REQ-018 SHALL give an MDU result direct-to-port path: empty FIFO, no pipe write, MDU accept at edge N -> RegWrite in cycle N+1 (no queue residency).
REQ-019 SHALL, with bypass disabled, tie bypX_valid=0 and bypX_data=0.

Reset
REQ-020 SHALL on rst=0 asynchronously clear FIFO, pointers, count and live bits; RegWrite=0, WriteReg=0, WriteData=0.
REQ-021 SHALL drive mdu_ready=0 during reset, 1 on the first cycle after release; pend1/pend2=0 during reset.
REQ-022 SHALL discard in-flight entries on reset mid-operation; no write issues for them after release.

Configuration
REQ-023 SHALL compile bypass logic only when WB_BYPASS_EN is defined.
REQ-024 SHALL, with WB_BYPASS_EN, drive bypX_valid=pendX and bypX_data=data of the live entry targeting rd_regX; without, REQ-019 applies and decode stalls on pendX.

Verification
REQ-025 SHALL cover: pipe write reg5=0x1234 at edge 1 -> RegWrite=1, WriteReg=5, WriteData=0x1234 in cycle 2, RegWrite=0 in cycle 3.
REQ-026 SHALL cover: pipe_valid held 6 cycles, MDU offers reg 8..12 -> four accepted, mdu_ready=0 fifth, after pipe drops four writes 8..11 consecutive, then 12.
REQ-027 SHALL cover: MDU enqueues reg7=0xAA, pipe writes reg7=0xBB while queued -> only 0xBB written to reg7, queued entry pops with RegWrite=0.
REQ-028 SHALL cover: MDU write to reg0 and pipe write to reg0 -> handshake completes, RegWrite never asserted, count stays 0.
REQ-029 SHALL cover: three queued entries, rst low mid-drain -> outputs zero immediately, no writes after release, mdu_ready=1.
REQ-030 SHALL cover: queued reg9=0xCAFE, rd_reg1=9 -> pend1=1; with WB_BYPASS_EN byp1_valid=1, byp1_data=0xCAFE; without, byp1_valid=0.

Source files
------------

// File: rtl/reg_writeback_ctrl.sv
// reg_writeback_ctrl: arbitrates WB-stage and MDU results onto one register-file write port.
// Optional combinational bypass from the MDU queue is compiled only when WB_BYPASS_EN is defined.
module reg_writeback_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_valid,
  input  logic [4:0]  pipe_reg,
  input  logic [31:0] pipe_data,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_reg,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  output logic        RegWrite,
  output logic [4:0]  WriteReg,
  output logic [31:0] WriteData,
  input  logic [4:0]  rd_reg1,
  input  logic [4:0]  rd_reg2,
  output logic        pend1,
  output logic        pend2,
  output logic        byp1_valid,
  output logic [31:0] byp1_data,
  output logic        byp2_valid,
  output logic [31:0] byp2_data
);
  logic [4:0]  q_reg [4];
  logic [31:0] q_data [4];
  logic [3:0]  q_live;
  logic [1:0]  rptr, wptr;
  logic [2:0]  count;
  logic        pipe_wr, mdu_en, pop, enq;
  assign mdu_ready = rst && (count < 3'd4);
  assign mdu_en    = mdu_valid && mdu_ready && (mdu_reg != '0);
  assign pipe_wr   = pipe_valid && (pipe_reg != '0);
  assign pop       = !pipe_wr && (count != '0);
  assign enq       = mdu_en && (pipe_wr || count != '0);
  // An MDU result accepted this cycle is treated as already queued.
  function automatic logic hit(input logic [4:0] r);
    hit = mdu_en && (mdu_reg == r);
    for (int i = 0; i < 4; i++)
      hit = hit || (q_live[i] && q_reg[i] == r);
    hit = hit && rst && (r != '0);
  endfunction
  always_comb begin
    pend1 = hit(rd_reg1);
    pend2 = hit(rd_reg2);
  end
`ifdef WB_BYPASS_EN
  function automatic logic [31:0] fwd(input logic [4:0] r);
    fwd = '0;
    for (int i = 0; i < 4; i++)
      if (q_live[i] && q_reg[i] == r) fwd = q_data[i];
    if (mdu_en && mdu_reg == r) fwd = mdu_data;
  endfunction
  always_comb begin
    byp1_valid = pend1;
    byp2_valid = pend2;
    byp1_data  = pend1 ? fwd(rd_reg1) : '0;
    byp2_data  = pend2 ? fwd(rd_reg2) : '0;
  end
`else
  assign byp1_valid = 1'b0;
  assign byp2_valid = 1'b0;
  assign byp1_data  = '0;
  assign byp2_data  = '0;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        q_reg[i]  <= '0;
        q_data[i] <= '0;
      end
      q_live    <= '0;
      rptr      <= '0;
      wptr      <= '0;
      count     <= '0;
      RegWrite  <= 1'b0;
      WriteReg  <= '0;
      WriteData <= '0;
    end else begin
      // Any newer write to a register supersedes older queued results for it.
      for (int i = 0; i < 4; i++)
        if ((pipe_wr && q_reg[i] == pipe_reg) || (mdu_en && q_reg[i] == mdu_reg)) q_live[i] <= 1'b0;
      if (pipe_wr) begin
        RegWrite  <= 1'b1;
        WriteReg  <= pipe_reg;
        WriteData <= pipe_data;
      end else if (pop) begin
        RegWrite <= q_live[rptr];
        if (q_live[rptr]) begin
          WriteReg  <= q_reg[rptr];
          WriteData <= q_data[rptr];
        end
        q_live[rptr] <= 1'b0;
        rptr         <= rptr + 2'd1;
      end else if (mdu_en) begin
        RegWrite  <= 1'b1;
        WriteReg  <= mdu_reg;
        WriteData <= mdu_data;
      end else
        RegWrite <= 1'b0;
      if (enq) begin
        q_reg[wptr]  <= mdu_reg;
        q_data[wptr] <= mdu_data;
        q_live[wptr] <= !(pipe_wr && pipe_reg == mdu_reg);
        wptr         <= wptr + 2'd1;
      end
      count <= count + {2'b0, enq} - {2'b0, pop};
    end
endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// tb_reg_writeback_ctrl: vector table for single-cycle behaviour plus scoreboarded write sequences.
module tb_reg_writeback_ctrl;
  logic        clk = 1'b0, rst = 1'b0;
  logic        pipe_valid = 1'b0, mdu_valid = 1'b0;
  logic [4:0]  pipe_reg = '0, mdu_reg = '0, rd_reg1 = '0, rd_reg2 = '0;
  logic [31:0] pipe_data = '0, mdu_data = '0;
  logic        mdu_ready, RegWrite, pend1, pend2, byp1_valid, byp2_valid;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData, byp1_data, byp2_data;

  reg_writeback_ctrl dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_reg(pipe_reg), .pipe_data(pipe_data),
    .mdu_valid(mdu_valid), .mdu_reg(mdu_reg), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .rd_reg1(rd_reg1), .rd_reg2(rd_reg2), .pend1(pend1), .pend2(pend2),
    .byp1_valid(byp1_valid), .byp1_data(byp1_data),
    .byp2_valid(byp2_valid), .byp2_data(byp2_data)
  );

  always #5 clk = ~clk;

  int passed = 0, total = 0;
  bit sb_on = 1'b0;
  typedef struct { logic [4:0] r; logic [31:0] d; } wr_t;
  wr_t exp_q[$];

  typedef struct {
    logic pv; logic [4:0] pr; logic [31:0] pd;
    logic mv; logic [4:0] mr; logic [31:0] md;
    logic rdy; logic rw; logic [4:0] wr; logic [31:0] wd;
  } vec_t;
  vec_t vt[9];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", n, act, exp);
  endtask

  task automatic drive(input logic pv, input logic [4:0] pr, input logic [31:0] pd,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md);
    pipe_valid = pv; pipe_reg = pr; pipe_data = pd;
    mdu_valid = mv; mdu_reg = mr; mdu_data = md;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] r, input logic [31:0] d);
    wr_t e;
    e.r = r;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < n; i++) tick;
  endtask

  always @(negedge clk)
    if (sb_on && rst && RegWrite) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL extra_write: got reg %0d data %h, expected no write", WriteReg, WriteData);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wb_reg", {27'd0, WriteReg}, {27'd0, e.r});
        chk("wb_data", WriteData, e.d);
      end
    end

  initial begin
    int k;
    logic acc;
    vt[0] = '{1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 5'd5, 32'h1234};
    vt[1] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 5'd5, 32'h1234};
    vt[2] = '{1'b1, 5'd0, 32'h66,   1'b1, 5'd0, 32'h55, 1'b1, 1'b0, 5'd5, 32'h1234};
    vt[3] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 5'd5, 32'h1234};
    vt[4] = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd3, 32'h33, 1'b1, 1'b1, 5'd3, 32'h33};
    vt[5] = '{1'b1, 5'd4, 32'h44,   1'b1, 5'd6, 32'h66, 1'b1, 1'b1, 5'd4, 32'h44};
    vt[6] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  1'b1, 1'b1, 5'd6, 32'h66};
    vt[7] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 5'd6, 32'h66};
    vt[8] = '{1'b1, 5'd0, 32'h77,   1'b1, 5'd0, 32'h88, 1'b1, 1'b0, 5'd6, 32'h66};

    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h5);
    rd_reg1 = 5'd5;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_regwrite", {31'd0, RegWrite}, 32'd0);
    chk("rst_writereg", {27'd0, WriteReg}, 32'd0);
    chk("rst_writedata", WriteData, 32'd0);
    chk("rst_ready", {31'd0, mdu_ready}, 32'd0);
    chk("rst_pend1", {31'd0, pend1}, 32'd0);
    mdu_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("release_ready", {31'd0, mdu_ready}, 32'd1);
    rd_reg1 = 5'd0;

    for (int i = 0; i < 9; i++) begin
      drive(vt[i].pv, vt[i].pr, vt[i].pd, vt[i].mv, vt[i].mr, vt[i].md);
      #1;
      chk($sformatf("v%0d_ready", i), {31'd0, mdu_ready}, {31'd0, vt[i].rdy});
      tick;
      chk($sformatf("v%0d_regwrite", i), {31'd0, RegWrite}, {31'd0, vt[i].rw});
      chk($sformatf("v%0d_writereg", i), {27'd0, WriteReg}, {27'd0, vt[i].wr});
      chk($sformatf("v%0d_writedata", i), WriteData, vt[i].wd);
    end
    idle(2);
    sb_on = 1'b1;

    // Queue fills behind a busy pipe, then drains in order.
    for (int c = 0; c < 6; c++) push(5'(20 + c), 32'h100 + c);
    for (int j = 0; j < 5; j++) push(5'(8 + j), 32'h800 + j);
    k = 0;
    for (int c = 0; c < 11; c++) begin
      drive(c < 6, 5'(20 + c), 32'h100 + c, k < 5, 5'(8 + k), 32'h800 + k);
      #1;
      if (c == 4 || c == 5) chk($sformatf("full_ready_c%0d", c), {31'd0, mdu_ready}, 32'd0);
      acc = mdu_valid && mdu_ready;
      tick;
      if (acc) k++;
    end
    chk("accepted_count", k, 5);
    idle(3);

    // Pipe write supersedes a queued MDU result for the same register.
    rd_reg2 = 5'd7;
    push(5'd1, 32'h11);
    push(5'd7, 32'hBB);
    drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd7, 32'hAA);
    tick;
    drive(1'b1, 5'd7, 32'hBB, 1'b0, 5'd0, 32'd0);
    #1;
    chk("pend2_queued7", {31'd0, pend2}, 32'd1);
    tick;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1;
    chk("pend2_killed7", {31'd0, pend2}, 32'd0);
    tick;
    chk("dead_pop_regwrite", {31'd0, RegWrite}, 32'd0);
    idle(2);
    rd_reg2 = 5'd0;

    // Pending query and bypass of a queued entry.
    rd_reg1 = 5'd9;
    rd_reg2 = 5'd10;
    push(5'd2, 32'h22);
    push(5'd3, 32'h33);
    push(5'd9, 32'hCAFE);
    drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd9, 32'hCAFE);
    #1;
    chk("pend1_same_cycle", {31'd0, pend1}, 32'd1);
    tick;
    drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0);
    #1;
    chk("pend1_queued", {31'd0, pend1}, 32'd1);
    chk("pend2_other", {31'd0, pend2}, 32'd0);
`ifdef WB_BYPASS_EN
    chk("byp1_valid", {31'd0, byp1_valid}, 32'd1);
    chk("byp1_data", byp1_data, 32'hCAFE);
`else
    chk("byp1_valid", {31'd0, byp1_valid}, 32'd0);
    chk("byp1_data", byp1_data, 32'h0);
`endif
    tick;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick;
    #1;
    chk("pend1_drained", {31'd0, pend1}, 32'd0);
    idle(2);

    // Reset while draining discards the rest of the queue.
    rd_reg1 = 5'd14;
    rd_reg2 = 5'd0;
    push(5'd20, 32'h20);
    push(5'd21, 32'h21);
    push(5'd22, 32'h22);
    push(5'd13, 32'hD13);
    drive(1'b1, 5'd20, 32'h20, 1'b1, 5'd13, 32'hD13);
    tick;
    drive(1'b1, 5'd21, 32'h21, 1'b1, 5'd14, 32'hD14);
    tick;
    drive(1'b1, 5'd22, 32'h22, 1'b1, 5'd15, 32'hD15);
    tick;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1;
    chk("pend1_before_rst", {31'd0, pend1}, 32'd1);
    tick;
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_regwrite", {31'd0, RegWrite}, 32'd0);
    chk("midrst_writereg", {27'd0, WriteReg}, 32'd0);
    chk("midrst_writedata", WriteData, 32'd0);
    chk("midrst_ready", {31'd0, mdu_ready}, 32'd0);
    chk("midrst_pend1", {31'd0, pend1}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("post_rst_ready", {31'd0, mdu_ready}, 32'd1);
    chk("post_rst_pend1", {31'd0, pend1}, 32'd0);
    idle(5);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
